smc_rd_strobe_lite19: RTL and testbench

Read-side strobe sequencer for the static memory controller. It accepts one read request at a time from the SMC request path and drives the external chip selects and the active-low output enable through programmable setup, strobe and turnaround phases. It captures the external read data at the end of the strobe phase and returns it with a one-cycle valid pulse. It is the read-direction counterpart of the write strobe/enable gating on the same external bus.

---
 rtl/smc_rd_strobe_lite19_if.sv | 29 ++
 rtl/smc_rd_strobe_lite19.sv | 146 ++++++++++++++
 tb/tb_smc_rd_strobe_lite19.sv | 216 +++++++++++++++++++++
 3 files changed

// File: rtl/smc_rd_strobe_lite19_if.sv
// Request/strobe bundle for the SMC read strobe sequencer.
// The master drives the request and the external data bus; the slave is the sequencer.
interface smc_rd_strobe_lite19_if #(
  parameter int DW   = 32,
  parameter int WS_W = 4
);
  logic            rd_req19;
  logic            rd_ack19;
  logic [3:0]      r_cs19;
  logic [1:0]      r_oe_setup19;
  logic [WS_W-1:0] r_oe_wait19;
  logic [1:0]      r_turn19;
  logic [DW-1:0]   smc_data_in19;
  logic [3:0]      smc_n_cs19;
  logic            smc_n_oe19;
  logic [DW-1:0]   rd_data19;
  logic            rd_valid19;
  logic            rd_busy19;

  modport master (
    output rd_req19, r_cs19, r_oe_setup19, r_oe_wait19, r_turn19, smc_data_in19,
    input  rd_ack19, smc_n_cs19, smc_n_oe19, rd_data19, rd_valid19, rd_busy19
  );

  modport slave (
    input  rd_req19, r_cs19, r_oe_setup19, r_oe_wait19, r_turn19, smc_data_in19,
    output rd_ack19, smc_n_cs19, smc_n_oe19, rd_data19, rd_valid19, rd_busy19
  );
endinterface

// File: rtl/smc_rd_strobe_lite19.sv
// Read strobe sequencer: IDLE -> SETUP -> STROBE -> TURN with registered CS/OE outputs.
// Optional macro SMC_RD_INREG_EN adds an input register on the read data bus (+1 cycle latency).
module smc_rd_strobe_lite19 #(
  parameter int DW   = 32,
  parameter int WS_W = 4
) (
  input logic                   sys_clk19,
  input logic                   sys_reset19,
  smc_rd_strobe_lite19_if.slave bus
);
  localparam int CW = WS_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_SETUP,
    ST_STROBE,
    ST_TURN
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [3:0]      cs_q, cs_d;
  logic [WS_W-1:0] wait_q, wait_d;
  logic [1:0]      turn_q, turn_d;
  logic [3:0]      n_cs_q;
  logic            n_oe_q;
  logic [DW-1:0]   rd_data_q;
  logic            rd_valid_q;
  logic            accept;
  logic            last_cnt;
  logic            capture;
  logic            cap_en;
  logic [DW-1:0]   cap_data;

  assign accept   = bus.rd_req19 && (state_q == ST_IDLE);
  assign last_cnt = (cnt_q == CW'(1));
  assign capture  = (state_q == ST_STROBE) && last_cnt;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    cs_d    = cs_q;
    wait_d  = wait_q;
    turn_d  = turn_q;
    case (state_q)
      ST_IDLE: begin
        if (accept) begin
          cs_d   = bus.r_cs19;
          wait_d = bus.r_oe_wait19;
          turn_d = bus.r_turn19;
          if (bus.r_oe_setup19 != 2'd0) begin
            state_d = ST_SETUP;
            cnt_d   = CW'(bus.r_oe_setup19);
          end else begin
            state_d = ST_STROBE;
            cnt_d   = CW'(bus.r_oe_wait19) + CW'(1);
          end
        end
      end
      ST_SETUP: begin
        if (last_cnt) begin
          state_d = ST_STROBE;
          cnt_d   = CW'(wait_q) + CW'(1);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_STROBE: begin
        if (last_cnt) begin
          if (turn_q != 2'd0) begin
            state_d = ST_TURN;
            cnt_d   = CW'(turn_q);
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      ST_TURN: begin
        if (last_cnt) begin
          state_d = ST_IDLE;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

`ifdef SMC_RD_INREG_EN
  logic [DW-1:0] din_q;
  logic          cap_pend_q;

  // The bus is registered unconditionally; capture uses the copy taken at the last STROBE edge.
  always_ff @(posedge sys_clk19) begin
    if (sys_reset19) begin
      din_q      <= '0;
      cap_pend_q <= 1'b0;
    end else begin
      din_q      <= bus.smc_data_in19;
      cap_pend_q <= capture;
    end
  end

  assign cap_en   = cap_pend_q;
  assign cap_data = din_q;
`else
  assign cap_en   = capture;
  assign cap_data = bus.smc_data_in19;
`endif

  // Strobes come from the next state so they change on the same edge as the FSM.
  always_ff @(posedge sys_clk19) begin
    if (sys_reset19) begin
      state_q    <= ST_IDLE;
      cnt_q      <= '0;
      cs_q       <= '0;
      wait_q     <= '0;
      turn_q     <= '0;
      n_cs_q     <= 4'hF;
      n_oe_q     <= 1'b1;
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      cs_q       <= cs_d;
      wait_q     <= wait_d;
      turn_q     <= turn_d;
      n_cs_q     <= ((state_d == ST_SETUP) || (state_d == ST_STROBE)) ? ~cs_d : 4'hF;
      n_oe_q     <= (state_d != ST_STROBE);
      rd_valid_q <= cap_en;
      if (cap_en) begin
        rd_data_q <= cap_data;
      end
    end
  end

  assign bus.rd_ack19   = (state_q == ST_IDLE);
  assign bus.rd_busy19  = (state_q != ST_IDLE);
  assign bus.smc_n_cs19 = n_cs_q;
  assign bus.smc_n_oe19 = n_oe_q;
  assign bus.rd_data19  = rd_data_q;
  assign bus.rd_valid19 = rd_valid_q;
endmodule

// File: tb/tb_smc_rd_strobe_lite19.sv
// Self-checking bench for smc_rd_strobe_lite19: vector table, scoreboard and corner sequences.
module tb_smc_rd_strobe_lite19;
`ifdef SMC_RD_INREG_EN
  localparam int LAT_EXTRA = 1;
`else
  localparam int LAT_EXTRA = 0;
`endif

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  smc_rd_strobe_lite19_if #(.DW(32), .WS_W(4)) bus ();

  smc_rd_strobe_lite19 #(.DW(32), .WS_W(4)) dut (
    .sys_clk19   (clk),
    .sys_reset19 (rst),
    .bus         (bus)
  );

  typedef struct {
    int          s;
    int          w;
    int          t;
    logic [3:0]  cs;
    logic [31:0] d;
  } vec_t;

  vec_t        vecs[8];
  int          n_checks = 0;
  int          n_errors = 0;
  logic [31:0] sb_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h, want %h at %0t", name, act, exp, $time);
    end
  endtask

  // Every valid pulse must match the oldest outstanding read.
  always @(negedge clk) begin
    if (!rst && bus.rd_valid19) begin
      if (sb_q.size() == 0) begin
        n_checks++;
        n_errors++;
        $display("FAIL sb_unexpected_valid: got data %h, want no valid at %0t", bus.rd_data19, $time);
      end else begin
        check("sb_data", bus.rd_data19, sb_q.pop_front());
      end
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout, want completion");
    $fatal(1, "watchdog");
  end

  // One read; entered just after a rising edge with the DUT idle.
  task automatic run_read(input int s, input int w, input int t, input logic [3:0] cs,
                          input logic [31:0] d);
    int         last;
    int         vlat;
    int         stop;
    logic [3:0] exp_cs;
    logic       exp_oe;
    logic       exp_busy;
    last = s + w + 2 + t;
    vlat = s + w + 2 + LAT_EXTRA;
    stop = (last > vlat) ? last : vlat;
    $display("read s=%0d w=%0d t=%0d cs=%b data=%h", s, w, t, cs, d);
    bus.rd_req19      = 1'b1;
    bus.r_cs19        = cs;
    bus.r_oe_setup19  = 2'(s);
    bus.r_oe_wait19   = 4'(w);
    bus.r_turn19      = 2'(t);
    bus.smc_data_in19 = ~d;
    @(negedge clk);
    check("ack_c0", 32'(bus.rd_ack19), 32'd1);
    check("oe_c0", 32'(bus.smc_n_oe19), 32'd1);
    @(posedge clk);
    #1;
    sb_q.push_back(d);
    // Scramble request fields after accept; the latched copies must govern.
    bus.rd_req19     = 1'b0;
    bus.r_cs19       = ~cs;
    bus.r_oe_setup19 = ~2'(s);
    bus.r_oe_wait19  = ~4'(w);
    bus.r_turn19     = ~2'(t);
    for (int k = 1; k <= stop; k++) begin
      bus.smc_data_in19 = (k == s + w + 1) ? d : (~d ^ 32'(k));
      @(negedge clk);
      exp_cs   = (k <= s + w + 1) ? ~cs : 4'hF;
      exp_oe   = !((k >= s + 1) && (k <= s + w + 1));
      exp_busy = (k <= s + w + 1 + t);
      check("n_cs", 32'(bus.smc_n_cs19), 32'(exp_cs));
      check("n_oe", 32'(bus.smc_n_oe19), 32'(exp_oe));
      check("busy", 32'(bus.rd_busy19), 32'(exp_busy));
      check("ack", 32'(bus.rd_ack19), 32'(!exp_busy));
      check("valid", 32'(bus.rd_valid19), 32'(k == vlat));
      @(posedge clk);
      #1;
    end
  endtask

  initial begin
    vecs[0] = '{0, 0, 0, 4'b0001, 32'hA5A5_0001};
    vecs[1] = '{2, 3, 1, 4'b0100, 32'h1234_5678};
    vecs[2] = '{3, 0, 3, 4'b1111, 32'hDEAD_BEEF};
    vecs[3] = '{1, 15, 2, 4'b0000, 32'h0F0F_0F0F};
    vecs[4] = '{0, 1, 0, 4'b1010, 32'hCAFE_F00D};
    vecs[5] = '{3, 15, 3, 4'b0011, 32'h8000_0001};
    vecs[6] = '{2, 0, 0, 4'b1000, 32'h1357_9BDF};
    vecs[7] = '{0, 4, 2, 4'b0110, 32'h2468_ACE0};

    rst               = 1'b1;
    bus.rd_req19      = 1'b0;
    bus.r_cs19        = '0;
    bus.r_oe_setup19  = '0;
    bus.r_oe_wait19   = '0;
    bus.r_turn19      = '0;
    bus.smc_data_in19 = '0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("rst_n_cs", 32'(bus.smc_n_cs19), 32'hF);
    check("rst_n_oe", 32'(bus.smc_n_oe19), 32'd1);
    check("rst_valid", 32'(bus.rd_valid19), 32'd0);
    check("rst_data", bus.rd_data19, 32'd0);
    check("rst_busy", 32'(bus.rd_busy19), 32'd0);
    check("rst_ack", 32'(bus.rd_ack19), 32'd1);
    @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++) begin
      run_read(vecs[i].s, vecs[i].w, vecs[i].t, vecs[i].cs, vecs[i].d);
    end

    // Back-to-back minimum-interval reads with the request held high.
    $display("back-to-back reads s=0 w=0 t=0 x4");
    bus.rd_req19     = 1'b1;
    bus.r_cs19       = 4'b0010;
    bus.r_oe_setup19 = 2'd0;
    bus.r_oe_wait19  = 4'd0;
    bus.r_turn19     = 2'd0;
    for (int i = 0; i < 4; i++) begin
      logic [31:0] d;
      d = 32'hB000_0000 + 32'(i);
      bus.smc_data_in19 = ~d;
      @(negedge clk);
      check("b2b_ack_c0", 32'(bus.rd_ack19), 32'd1);
      check("b2b_oe_c0", 32'(bus.smc_n_oe19), 32'd1);
      check("b2b_valid_c0", 32'(bus.rd_valid19), 32'((i > 0) && (LAT_EXTRA == 0)));
      @(posedge clk);
      #1;
      sb_q.push_back(d);
      bus.smc_data_in19 = d;
      if (i == 3) bus.rd_req19 = 1'b0;
      @(negedge clk);
      check("b2b_ack_c1", 32'(bus.rd_ack19), 32'd0);
      check("b2b_oe_c1", 32'(bus.smc_n_oe19), 32'd0);
      check("b2b_cs_c1", 32'(bus.smc_n_cs19), 32'hD);
      check("b2b_valid_c1", 32'(bus.rd_valid19), 32'((i > 0) && (LAT_EXTRA == 1)));
      @(posedge clk);
      #1;
    end
    bus.smc_data_in19 = 32'h0;
    @(negedge clk);
    check("b2b_tail_valid2", 32'(bus.rd_valid19), 32'(LAT_EXTRA == 0));
    check("b2b_tail_ack", 32'(bus.rd_ack19), 32'd1);
    @(posedge clk);
    #1;
    @(negedge clk);
    check("b2b_tail_valid3", 32'(bus.rd_valid19), 32'(LAT_EXTRA == 1));
    @(posedge clk);
    #1;

    // Reset in cycle 4 of an S=1, W=5 read discards the read entirely.
    $display("reset abort s=1 w=5 t=0");
    bus.rd_req19      = 1'b1;
    bus.r_cs19        = 4'b0001;
    bus.r_oe_setup19  = 2'd1;
    bus.r_oe_wait19   = 4'd5;
    bus.r_turn19      = 2'd0;
    bus.smc_data_in19 = 32'h7777_7777;
    @(posedge clk);
    #1;
    bus.rd_req19 = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    @(negedge clk);
    check("abort_oe_c4", 32'(bus.smc_n_oe19), 32'd0);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    check("abort_n_oe", 32'(bus.smc_n_oe19), 32'd1);
    check("abort_n_cs", 32'(bus.smc_n_cs19), 32'hF);
    check("abort_busy", 32'(bus.rd_busy19), 32'd0);
    check("abort_ack", 32'(bus.rd_ack19), 32'd1);
    for (int k = 0; k < 8; k++) begin
      check("abort_no_valid", 32'(bus.rd_valid19), 32'd0);
      @(negedge clk);
    end

    check("sb_empty", 32'(sb_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule
